// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one datamem port between the CPU (r0) and DMA/debug (r1).
// Each access takes three cycles: latch, one memory cycle, one completion cycle.
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [63:0] r0_addr,
  input  logic [63:0] r0_wdata,
  input  logic [3:0]  r0_size,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [63:0] r1_addr,
  input  logic [63:0] r1_wdata,
  input  logic [3:0]  r1_size,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [63:0] mem_wr_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] MB = 4'(MAX_BURST);

  state_t      state, state_d;
  logic [3:0]  burst_cnt, burst_cnt_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic        ill_q, ill_d;

  logic        gnt0_d, gnt1_d, done0_d, done1_d, err_d;
  logic [63:0] rdata_d, mem_addr_d, mem_wr_data_d;
  logic        mem_wr_en_d, mem_rd_en_d;
  logic [3:0]  mem_xfer_size_d;

  logic        pick1;
  logic        sel_we;
  logic [63:0] sel_addr, sel_wdata;
  logic [3:0]  sel_size;
  logic        sel_ok;

  // r1 wins when alone or when r0 has used up its burst allowance
  assign pick1     = r1_req && (!r0_req || burst_cnt == MB);
  assign sel_we    = pick1 ? r1_we    : r0_we;
  assign sel_addr  = pick1 ? r1_addr  : r0_addr;
  assign sel_wdata = pick1 ? r1_wdata : r0_wdata;
  assign sel_size  = pick1 ? r1_size  : r0_size;

  always_comb begin
    sel_ok = 1'b0;
    case (sel_size)
      4'd1:    sel_ok = 1'b1;
      4'd2:    sel_ok = (sel_addr[0] == 1'b0);
      4'd4:    sel_ok = (sel_addr[1:0] == 2'b00);
      4'd8:    sel_ok = (sel_addr[2:0] == 3'b000);
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state;
    burst_cnt_d     = burst_cnt;
    id_d            = id_q;
    we_d            = we_q;
    ill_d           = ill_q;
    gnt0_d          = 1'b0;
    gnt1_d          = 1'b0;
    done0_d         = 1'b0;
    done1_d         = 1'b0;
    err_d           = 1'b0;
    rdata_d         = '0;
    mem_addr_d      = '0;
    mem_wr_en_d     = 1'b0;
    mem_rd_en_d     = 1'b0;
    mem_wr_data_d   = '0;
    mem_xfer_size_d = '0;
    unique case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_d = ISSUE;
          id_d    = pick1;
          we_d    = sel_we;
          ill_d   = !sel_ok;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          if (pick1 || !r1_req)
            burst_cnt_d = '0;
          else if (burst_cnt != MB)
            burst_cnt_d = burst_cnt + 4'd1;
          // rejected requests never reach the memory port
          if (sel_ok) begin
            mem_addr_d      = sel_addr;
            mem_wr_data_d   = sel_wdata;
            mem_xfer_size_d = sel_size;
            mem_wr_en_d     = sel_we;
            mem_rd_en_d     = !sel_we;
          end
        end
      end
      ISSUE: begin
        state_d = RESP;
        done0_d = !id_q;
        done1_d = id_q;
        err_d   = ill_q;
        if (!ill_q && !we_q)
          rdata_d = mem_rd_data;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state     <= state_d;
      burst_cnt <= burst_cnt_d;
      id_q      <= id_d;
      we_q      <= we_d;
      ill_q     <= ill_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      done0         <= 1'b0;
      done1         <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      mem_addr      <= '0;
      mem_wr_en     <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_wr_data   <= '0;
      mem_xfer_size <= '0;
    end else begin
      gnt0          <= gnt0_d;
      gnt1          <= gnt1_d;
      done0         <= done0_d;
      done1         <= done1_d;
      err           <= err_d;
      rdata         <= rdata_d;
      mem_addr      <= mem_addr_d;
      mem_wr_en     <= mem_wr_en_d;
      mem_rd_en     <= mem_rd_en_d;
      mem_wr_data   <= mem_wr_data_d;
      mem_xfer_size <= mem_xfer_size_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the `datamem` data memory. It shares the single memory port between requester 0 (CPU load/store path) and requester 1 (DMA/debug port). Each access is a fixed three-phase transaction:
- latch the request;
- issue exactly one memory cycle;
- return a one-cycle completion.

Requester 0 has priority, and a starvation limit guarantees requester 1 a grant. Illegal size or alignment is rejected without touching memory.

## Interface
Parameters:
- MAX_BURST, 4, max consecutive requester-0 grants while requester 1 waits (legal range 1..15)

Ports (clock and reset first; one clock domain; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  requester 0 access request
- r0_we  in  1  requester 0: 1 = write, 0 = read
- r0_addr  in  64  requester 0 byte address
- r0_wdata  in  64  requester 0 write data
- r0_size  in  4  requester 0 transfer size in bytes
- r1_req  in  1  requester 1 access request
- r1_we  in  1  requester 1: 1 = write, 0 = read
- r1_addr  in  64  requester 1 byte address
- r1_wdata  in  64  requester 1 write data
- r1_size  in  4  requester 1 transfer size in bytes
- gnt0, gnt1  out  1  request accepted (one-cycle pulse each)
- done0, done1  out  1  transaction complete (one-cycle pulse each)
- err  out  1  valid with doneX; illegal size or misaligned address
- rdata  out  64  read result, valid with doneX on a legal read
- mem_addr  out  64  to datamem address
- mem_wr_en  out  1  to datamem write_enable
- mem_rd_en  out  1  to datamem read_enable
- mem_wr_data  out  64  to datamem write_data
- mem_xfer_size  out  4  to datamem xfer_size
- mem_rd_data  in  64  from datamem read_data (combinational read within the enable cycle)

## Operation
- FSM states: IDLE, ISSUE, RESP. Transitions are IDLE→ISSUE (some req sampled high), ISSUE→RESP (always), RESP→IDLE (always).
- Arbitration happens in IDLE at the clock edge:
  - One req high: that requester wins.
  - Both high: requester 0 wins, unless burst_cnt == MAX_BURST, in which case requester 1 wins.
- Winning request fields (we, addr, wdata, size) and the winner id are latched at that same edge.
- burst_cnt (4-bit), updated at each arbitration:
  - +1 when 0 wins while r1_req is high.
  - Cleared when 1 wins.
  - Cleared when 0 wins with r1_req low.
  - Saturates at MAX_BURST.
- Legality check on the latched fields:
  - size must be in {1, 2, 4, 8};
  - addr must be a multiple of size (addr mod size == 0).
- ISSUE, legal request:
  - mem_addr, mem_wr_data and mem_xfer_size driven from the latched fields;
  - exactly one of mem_wr_en or mem_rd_en high;
  - on a read, mem_rd_data is captured into rdata at the end of ISSUE.
- ISSUE, illegal request: both memory enables stay 0.
- RESP:
  - done of the winner is high;
  - err = illegal;
  - rdata holds the captured read data for a legal read, otherwise 0.
- Outside ISSUE, all mem_* outputs are 0.
- Rejected transactions count as grants for arbitration and burst_cnt.
- Requester handshake rules:
  - Hold req and the request fields stable until gntX is seen.
  - req still high in IDLE after done is a new request.

## Timing
- All outputs are registered.
- Reset values: state IDLE, burst_cnt 0, all outputs 0.
- Reset mid-transaction aborts the access. No done is produced, the memory enables drop immediately, and a write in ISSUE may or may not commit.
- Cycle sequence, with the request sampled at the end of cycle N:
  - N+1: ISSUE, gntX = 1, memory access;
  - N+2: RESP, doneX = 1 (plus err/rdata);
  - N+3: IDLE.
- Latency is 2 cycles from the sample edge to done. Peak throughput is 1 transaction per 3 cycles.
- A request arriving during ISSUE or RESP waits. The first possible sample is the end of the IDLE cycle.
- gnt0/gnt1, done0/done1 and the two memory enables are mutually exclusive; at most one of each pair is high.

## Test plan
- Single read: r0 read, addr 0x10, size 8, memory returns 0xDEADBEEF_00000001. Expect gnt0 at N+1 with mem_rd_en=1 and mem_addr=0x10; done0 at N+2 with rdata=0xDEADBEEF_00000001 and err=0.
- Single write: r1 write, addr 0x20, wdata 0x55, size 4. Expect mem_wr_en=1, mem_wr_data=0x55, mem_xfer_size=4 for exactly one cycle; then done1 with err=0.
- Fairness: r0_req and r1_req held high continuously, MAX_BURST=4. Expect grant order 0,0,0,0,1,0,0,0,0,1, with each grant 3 cycles apart.
- Errors:
  - size 3: err=1 with done, no memory enables;
  - addr 0x6 with size 4: err=1, no memory enables;
  - addr 0x8 with size 8: legal, err=0.
- Simultaneous first requests from IDLE with burst_cnt=0: r0 wins. r1 stays pending and wins as soon as r0_req drops.
- Reset asserted in ISSUE of a read: all outputs go to 0 asynchronously and no done appears. After release, a new r1 request completes normally.
